vertex_transform: RTL and testbench
===================================

# vertex_transform

Sequential 4x4 matrix-by-vertex transformer that sits directly downstream of the model-matrix generator. It latches a 16-element signed fixed-point matrix, accepts object-space vertices (x, y, z, implicit w = 1) over a valid/ready handshake, and emits the transformed homogeneous vertex (x', y', z', w'). It uses one shared multiplier and one accumulator, taking 12 multiply-accumulate cycles per vertex.

## Interface
Parameters:
- WI, 8, integer bits of every fixed-point value (signed, two's complement, sign bit included)
- WF, 8, fractional bits of every fixed-point value; input and output share the Q(WI).(WF) format

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mat_load  in  1  latch `mat`; honoured only while `in_ready`=1
- mat  in  [15:0][WI+WF-1:0]  row-major matrix; element index = 4*row+col
- in_valid  in  1  vertex offered
- in_ready  out  1  block idle, can accept a vertex
- in_x, in_y, in_z  in  WI+WF each  object-space vertex
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts the result
- out_x, out_y, out_z, out_w  out  WI+WF each  transformed vertex
- out_ovf  out  1  at least one of the four outputs saturated for this vertex

## Operation
- States: IDLE, CALC, DONE. `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- Matrix register M: reset value is identity (diagonal = 1<<WF, others 0). In IDLE, `mat_load`=1 writes M. In CALC or DONE it is ignored.
- If `mat_load` and `in_valid` are both high in IDLE at the same edge, the vertex uses the new matrix.
- IDLE -> CALC on `in_valid`&&`in_ready`:
  - latch v[0..2] = in_x, in_y, in_z
  - cnt <= 0
  - acc <= sign-extended M[3] << WF
- CALC, cnt = 0..11: row r = cnt/3, col c = cnt%3.
  - acc_next = acc + M[4r+c]*v[c], a full-precision signed 2(WI+WF)-bit product.
  - acc is at least 2(WI+WF)+2 bits wide, so it never overflows internally.
- At c==2, the result register for row r is written with round(acc_next):
  - add 1<<(WF-1), then arithmetic shift right by WF (round half toward +infinity);
  - saturate to [-2^(WI+WF-1), 2^(WI+WF-1)-1];
  - if saturation occurs, set the per-vertex overflow flag.
  - Then acc <= M[4(r+1)+3] << WF.
- After cnt==11: state <= DONE, `out_ovf` <= OR of the four saturation flags. The flags clear on CALC entry.
- DONE -> IDLE on `out_ready`. Outputs hold their values while `out_ready`=0 and keep the last result after returning to IDLE.
- Asynchronous reset (including mid-CALC or in DONE):
  - state IDLE, cnt 0, acc 0
  - all out_* = 0, `out_ovf` = 0, `out_valid` = 0
  - M = identity
  - `in_ready` = 1 immediately after reset deassertion.

## Timing
- Acceptance edge A: CALC runs on edges A+1 through A+12. `out_valid` rises after edge A+12 (latency 12 cycles).
- Earliest handshake is `out_ready` at edge A+13. `in_ready` is high after A+13, so the next acceptance is at A+14 at the earliest, for a throughput of 1 vertex per 14 cycles.
- No overlap: `in_ready`=0 from A+1 until DONE completes.
- out_* registers change only on row-completion edges in CALC. They are stable throughout DONE.
- No combinational path from in_* or out_ready to any output.

## Test plan
- **Identity.** Reset, no load. Vertex (0x0180, 0xFE00, 0x0300) -> out (0x0180, 0xFE00, 0x0300, 0x0100), ovf=0, `out_valid` exactly 12 cycles after acceptance.
- **Scale and translate.**
  - Load diag 0x0280 (2.5), M[3]=0x0100, M[7]=0xFF00, M[11]=0x0080, M[15]=0x0100.
  - Vertex (0x0100, 0x0100, 0x0100) -> (0x0380, 0x0180, 0x0300, 0x0100).
  - Repeat with `mat_load` asserted in the same cycle as `in_valid`, and confirm the new matrix is used.
- **Rounding and saturation.**
  - M[0]=0x0001, vertex x=0x0080 -> out_x=0x0001.
  - x=0xFF80 -> out_x=0x0000.
  - M[0]=0x7F00, x=0x0200 -> out_x=0x7FFF, ovf=1.
  - M[0]=0x7F00, x=0xFE00 -> out_x=0x8000, ovf=1.
- **Backpressure.**
  - Hold `out_ready`=0 for 5 cycles in DONE: outputs stable, `in_ready`=0, `in_valid` ignored.
  - Pulse `mat_load` during CALC: no effect on the current or next vertex.
- **Reset mid-operation.** Assert `rst_n`=0 at cnt=6: outputs zero at once, M = identity. After release, a vertex (0x0100, 0x0200, 0x0300) returns identity results.
- **Back-to-back.** 8 random vertices with `out_ready` tied high: acceptances exactly 14 cycles apart, results match a golden model bit-exactly.

Source files
------------

// File: rtl/vertex_transform_if.sv
// vertex_transform_if: matrix load, vertex input and result handshake bundle.
//   master : upstream/consumer side (drives mat/in_*/out_ready)
//   slave  : vertex_transform side (drives in_ready, out_*)
//   mat           [15:0][W-1:0] row-major matrix, element 4*row+col
//   in_x/y/z      object-space vertex, Q(WI).(WF)
//   out_x/y/z/w   transformed homogeneous vertex, Q(WI).(WF)
//   out_ovf       one or more outputs saturated for this vertex
interface vertex_transform_if #(
    parameter int WI = 8,
    parameter int WF = 8
);
    localparam int W = WI + WF;

    logic                mat_load;
    logic [15:0][W-1:0]  mat;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_x, in_y, in_z;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_x, out_y, out_z, out_w;
    logic                out_ovf;

    modport master (
        output mat_load, mat, in_valid, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_w, out_ovf
    );

    modport slave (
        input  mat_load, mat, in_valid, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_w, out_ovf
    );
endinterface

// File: rtl/vertex_transform.sv
// vertex_transform: sequential 4x4 matrix * (x,y,z,1) transformer.
// One shared multiplier and accumulator, 12 MAC cycles per vertex.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vertex_transform_if.slave (matrix load, vertex in, result out)
// Row r result = round(M[4r+3]<<WF + sum_c M[4r+c]*v[c]), rounded half
// toward +inf and saturated to the Q(WI).(WF) range.
module vertex_transform #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    vertex_transform_if.slave   bus
);
    localparam int W  = WI + WF;
    localparam int AW = 2 * W + 2;

    localparam logic signed [AW-1:0] HALF = AW'(1) << (WF - 1);
    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]         ONE  = W'(1) << WF;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt;
    logic signed [AW-1:0]   acc;
    logic [15:0][W-1:0]     m;
    logic [2:0][W-1:0]      v;
    logic [3:0][W-1:0]      res;
    logic                   ovf_flag;
    logic                   ovf_out;

    logic [1:0]             row, col;
    logic signed [W-1:0]    coef, vin;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   acc_nxt, rnd;
    logic                   sat_hi, sat_lo;
    logic [W-1:0]           sat_val;

    // Translation term M[k] placed at the product's binary point.
    function automatic logic signed [AW-1:0] pre(input logic [W-1:0] a);
        logic signed [AW-1:0] t;
        t = {{(AW-W){a[W-1]}}, a};
        return t <<< WF;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CALC;
            CALC:    if (cnt == 4'd11)  state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- MAC datapath ----------------
    always_comb begin
        row     = 2'(cnt / 4'd3);
        col     = 2'(cnt % 4'd3);
        coef    = m[{row, 2'b00} | {2'b00, col}];
        vin     = v[col];
        prod    = coef * vin;
        acc_nxt = acc + {{2{prod[2*W-1]}}, prod};
        rnd     = (acc_nxt + HALF) >>> WF;
        sat_hi  = rnd > SMAX;
        sat_lo  = rnd < SMIN;
        sat_val = sat_hi ? {1'b0, {(W-1){1'b1}}} :
                  sat_lo ? {1'b1, {(W-1){1'b0}}} : rnd[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            v        <= '0;
            res      <= '0;
            ovf_flag <= 1'b0;
            ovf_out  <= 1'b0;
            for (int i = 0; i < 16; i++) m[i] <= (i % 5 == 0) ? ONE : '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mat_load) m <= bus.mat;
                    if (bus.in_valid) begin
                        v        <= {bus.in_z, bus.in_y, bus.in_x};
                        cnt      <= '0;
                        ovf_flag <= 1'b0;
                        // Same-edge load: the vertex sees the incoming matrix.
                        acc      <= pre(bus.mat_load ? bus.mat[3] : m[3]);
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (col == 2'd2) begin
                        res[row] <= sat_val;
                        if (sat_hi || sat_lo) ovf_flag <= 1'b1;
                        // Seed next row; wraps to M[3] after row 3, unused.
                        acc <= pre(m[{row + 2'd1, 2'b11}]);
                        if (cnt == 4'd11) ovf_out <= ovf_flag | sat_hi | sat_lo;
                    end else begin
                        acc <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_x     = res[0];
    assign bus.out_y     = res[1];
    assign bus.out_z     = res[2];
    assign bus.out_w     = res[3];
    assign bus.out_ovf   = ovf_out;
endmodule

// File: tb/tb_vertex_transform.sv
module tb_vertex_transform;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    vertex_transform_if #(.WI(8), .WF(8)) bus ();
    vertex_transform #(.WI(8), .WF(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [15:0][15:0] ident, scale, mixed, junk;

    task automatic load_mat(input logic [15:0][15:0] mm);
        bus.mat = mm; bus.mat_load = 1'b1;
        @(posedge clk); #1;
        bus.mat_load = 1'b0;
    endtask

    // Offer one vertex in IDLE, return edges from acceptance to out_valid.
    task automatic send(input logic [15:0] x, y, z, input bit ld,
                        input logic [15:0][15:0] mm, output int lat);
        bus.in_x = x; bus.in_y = y; bus.in_z = z;
        if (ld) bus.mat = mm;
        bus.mat_load = ld; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.mat_load = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic model(input logic [15:0][15:0] mm, input logic [2:0][15:0] vv,
                         output logic [3:0][15:0] r, output bit o);
        longint s;
        o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = longint'($signed(mm[4*k+3])) * 256;
            for (int c = 0; c < 3; c++)
                s += longint'($signed(mm[4*k+c])) * longint'($signed(vv[c]));
            s = (s + 128) >>> 8;
            if (s > 32767)       begin r[k] = 16'h7FFF; o = 1'b1; end
            else if (s < -32768) begin r[k] = 16'h8000; o = 1'b1; end
            else                 r[k] = 16'(s);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        n_cmp++; if ({bus.in_ready, bus.out_valid, bus.out_ovf} !== 3'b100) begin n_err++;
            $display("FAIL reset_flags: got %b want 100", {bus.in_ready, bus.out_valid, bus.out_ovf}); end
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0) begin n_err++;
            $display("FAIL reset_out: got %h want 0", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_identity();
        int lat;
        send(16'h0180, 16'hFE00, 16'h0300, 1'b0, ident, lat);
        n_cmp++; if (lat !== 12) begin n_err++;
            $display("FAIL ident_latency: got %0d want 12", lat); end
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0180_FE00_0300_0100) begin n_err++;
            $display("FAIL ident_out: got %h want 0180fe0003000100", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++;
            $display("FAIL ident_ovf: got %b want 0", bus.out_ovf); end
        pop();
    endtask

    task automatic test_scale_translate();
        int lat;
        send(16'h0100, 16'h0100, 16'h0100, 1'b1, scale, lat);
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0380_0180_0300_0100) begin n_err++;
            $display("FAIL scale_out: got %h want 0380018003000100", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        pop();
        load_mat(ident);
        // mat_load and in_valid on the same edge
        send(16'h0100, 16'h0100, 16'h0100, 1'b1, scale, lat);
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0380_0180_0300_0100) begin n_err++;
            $display("FAIL scale_same_edge: got %h want 0380018003000100", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        pop();
    endtask

    task automatic test_round_sat();
        logic [15:0][15:0] mm;
        logic [3:0][15:0]  xs, want;
        logic [3:0]        ovfs;
        int lat;
        xs   = {16'hFE00, 16'h0200, 16'hFF80, 16'h0080};
        want = {16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
        ovfs = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            mm = ident;
            mm[0] = (i < 2) ? 16'h0001 : 16'h7F00;
            send(xs[i], 16'h0000, 16'h0000, 1'b1, mm, lat);
            n_cmp++; if (bus.out_x !== want[i]) begin n_err++;
                $display("FAIL round_sat_x[%0d]: got %h want %h", i, bus.out_x, want[i]); end
            n_cmp++; if (bus.out_ovf !== ovfs[i]) begin n_err++;
                $display("FAIL round_sat_ovf[%0d]: got %b want %b", i, bus.out_ovf, ovfs[i]); end
            n_cmp++; if (bus.out_w !== 16'h0100) begin n_err++;
                $display("FAIL round_sat_w[%0d]: got %h want 0100", i, bus.out_w); end
            pop();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        load_mat(ident);
        bus.in_x = 16'h0123; bus.in_y = 16'h0456; bus.in_z = 16'hF789;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        bus.mat = junk; bus.mat_load = 1'b1;   // ignored during CALC
        @(posedge clk); #1;
        bus.mat_load = 1'b0;
        lat = 4;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== 12) begin n_err++;
            $display("FAIL bp_latency: got %0d want 12", lat); end
        bus.in_valid = 1'b1; bus.in_x = 16'h7777;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({bus.out_valid, bus.in_ready, bus.out_ovf, bus.out_x, bus.out_y, bus.out_z, bus.out_w}
                         !== {3'b100, 64'h0123_0456_F789_0100}) begin n_err++;
                $display("FAIL bp_hold[%0d]: got %b %h", k, {bus.out_valid, bus.in_ready, bus.out_ovf},
                         {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        pop();
        n_cmp++; if ({bus.in_ready, bus.out_x} !== {1'b1, 16'h0123}) begin n_err++;
            $display("FAIL bp_after_pop: got %b %h want 1 0123", bus.in_ready, bus.out_x); end
        send(16'h0200, 16'hFF00, 16'h0010, 1'b0, ident, lat);
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0200_FF00_0010_0100) begin n_err++;
            $display("FAIL bp_next_vertex: got %h want 0200ff0000100100", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        pop();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(16'h0100, 16'h0100, 16'h0100, 1'b1, scale, lat);
        pop();
        bus.in_x = 16'h0100; bus.in_y = 16'h0100; bus.in_z = 16'h0100;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w, bus.out_ovf, bus.out_valid, bus.in_ready}
                     !== {64'h0, 3'b001}) begin n_err++;
            $display("FAIL rstmid_out: got %h %b", {bus.out_x, bus.out_y, bus.out_z, bus.out_w},
                     {bus.out_ovf, bus.out_valid, bus.in_ready}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h0100, 16'h0200, 16'h0300, 1'b0, ident, lat);
        n_cmp++; if (lat !== 12) begin n_err++;
            $display("FAIL rstmid_latency: got %0d want 12", lat); end
        n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w} !== 64'h0100_0200_0300_0100) begin n_err++;
            $display("FAIL rstmid_ident: got %h want 0100020003000100", {bus.out_x, bus.out_y, bus.out_z, bus.out_w}); end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [2:0][15:0] vq   [8];
        logic [3:0][15:0] expq [8];
        bit               expo [8];
        int acc_cyc [8];
        int cyc, i_acc, i_out;
        bit acc_now;
        load_mat(mixed);
        for (int i = 0; i < 8; i++) begin
            vq[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
            model(mixed, vq[i], expq[i], expo[i]);
        end
        bus.out_ready = 1'b1;
        bus.in_x = vq[0][0]; bus.in_y = vq[0][1]; bus.in_z = vq[0][2];
        bus.in_valid = 1'b1;
        cyc = 0; i_acc = 0; i_out = 0;
        while (i_out < 8 && cyc < 400) begin
            if (bus.out_valid) begin
                n_cmp++; if ({bus.out_x, bus.out_y, bus.out_z, bus.out_w, bus.out_ovf}
                             !== {expq[i_out][0], expq[i_out][1], expq[i_out][2], expq[i_out][3], expo[i_out]}) begin
                    n_err++;
                    $display("FAIL b2b_out[%0d]: got %h %b want %h %h %h %h %b", i_out,
                             {bus.out_x, bus.out_y, bus.out_z, bus.out_w}, bus.out_ovf,
                             expq[i_out][0], expq[i_out][1], expq[i_out][2], expq[i_out][3], expo[i_out]);
                end
                i_out++;
            end
            acc_now = bus.in_ready && bus.in_valid;
            @(posedge clk); #1; cyc++;
            if (acc_now) begin
                acc_cyc[i_acc] = cyc;
                i_acc++;
                if (i_acc < 8) begin
                    bus.in_x = vq[i_acc][0]; bus.in_y = vq[i_acc][1]; bus.in_z = vq[i_acc][2];
                end else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (i_out !== 8) begin n_err++;
            $display("FAIL b2b_count: got %0d results want 8", i_out); end
        for (int i = 1; i < i_acc; i++) begin
            n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] !== 14) begin n_err++;
                $display("FAIL b2b_gap[%0d]: got %0d want 14", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
            junk[i]  = 16'h0400;
        end
        scale = ident;
        scale[0] = 16'h0280; scale[5] = 16'h0280; scale[10] = 16'h0280;
        scale[3] = 16'h0100; scale[7] = 16'hFF00; scale[11] = 16'h0080; scale[15] = 16'h0100;
        mixed = {16'h0100, 16'h0000, 16'h0000, 16'h0000,
                 16'h0080, 16'h00C0, 16'h0010, 16'hFFC0,
                 16'hFF00, 16'hFE80, 16'h0200, 16'h0040,
                 16'h0100, 16'h0020, 16'hFF40, 16'h0180};
        bus.mat_load = 1'b0; bus.mat = '0; bus.in_valid = 1'b0;
        bus.in_x = '0; bus.in_y = '0; bus.in_z = '0; bus.out_ready = 1'b0;

        test_reset();
        test_identity();
        test_scale_translate();
        test_round_sat();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
